pe_array_tile_ctrl: RTL

//   Tile sequencer for PE_array. Per tile it runs three phases: weight preload (w_en),

---
 rtl/pe_array_tile_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/pe_array_tile_ctrl.sv
// Tile sequencer for PE_array: weight preload, activation streaming, then a
// skew-flushing drain, with a valid pipe that flags finished out_sum beats.
module pe_array_tile_ctrl #(
  parameter int data_width         = 19,
  parameter int a_tile_row_size    = 4,
  parameter int w_tile_column_size = 2,
  parameter int CNT_W              = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] cfg_num_vec,
  input  logic             wt_valid,
  output logic             wt_ready,
  input  logic             act_valid,
  output logic             act_ready,
  output logic             act_bubble,
  output logic             w_en,
  output logic             w_compute,
  output logic             sum_valid,
  output logic             busy,
  output logic             done
);

  localparam int LAT    = a_tile_row_size + w_tile_column_size - 1;
  localparam int WCNT_W = $clog2(a_tile_row_size + 1);
  localparam int DCNT_W = $clog2(LAT + 1);

  if (data_width < 1 || a_tile_row_size < 1 || w_tile_column_size < 1) begin : g_bad_cfg
    $error("pe_array_tile_ctrl: array dimensions and data_width must be positive");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_COMPUTE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic [CNT_W-1:0]   vcnt_q, vcnt_d;
  logic [DCNT_W-1:0]  dcnt_q, dcnt_d;
  logic [CNT_W-1:0]   num_vec_q, num_vec_d;
  logic [LAT-1:0]     pipe_q, pipe_d;
  logic               abort_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wcnt_q    <= '0;
      vcnt_q    <= '0;
      dcnt_q    <= '0;
      num_vec_q <= '0;
      pipe_q    <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      vcnt_q    <= vcnt_d;
      dcnt_q    <= dcnt_d;
      num_vec_q <= num_vec_d;
      pipe_q    <= pipe_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    vcnt_d     = vcnt_q;
    dcnt_d     = dcnt_q;
    num_vec_d  = num_vec_q;
    pipe_d     = pipe_q;
    wt_ready   = 1'b0;
    w_en       = 1'b0;
    act_ready  = 1'b0;
    act_bubble = 1'b0;
    w_compute  = 1'b0;
    done       = 1'b0;
    busy       = (state_q != S_IDLE);
    abort_hit  = abort && (state_q != S_IDLE);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_LOAD_W;
          num_vec_d = cfg_num_vec;
          wcnt_d    = '0;
          vcnt_d    = '0;
          dcnt_d    = '0;
        end
      end
      S_LOAD_W: begin
        wt_ready = 1'b1;
        w_en     = wt_valid;
        if (wt_valid) begin
          wcnt_d = wcnt_q + 1'b1;
          if (wcnt_q == WCNT_W'(a_tile_row_size - 1)) begin
            state_d = (num_vec_q == '0) ? S_DONE : S_COMPUTE;
          end
        end
      end
      S_COMPUTE: begin
        act_ready = 1'b1;
        w_compute = act_valid;
        if (act_valid) begin
          vcnt_d = vcnt_q + 1'b1;
          if (vcnt_q == num_vec_q - CNT_W'(1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        act_bubble = 1'b1;
        w_compute  = 1'b1;
        dcnt_d     = dcnt_q + 1'b1;
        if (dcnt_q == DCNT_W'(LAT - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort gates the enables in its own cycle so the array never advances on it.
    if (abort_hit) begin
      state_d   = S_IDLE;
      wt_ready  = 1'b0;
      w_en      = 1'b0;
      act_ready = 1'b0;
      w_compute = 1'b0;
      done      = 1'b0;
    end

    if (w_compute) begin
      pipe_d = (pipe_q << 1) | LAT'(state_q == S_COMPUTE && act_valid);
    end
    if (abort_hit) begin
      pipe_d = '0;
    end
    sum_valid = pipe_q[LAT-1] && w_compute;
  end

endmodule
